// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, register offsets and STATUS bit positions
// for the memory-mapped UART ports.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int STAT_FULL     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_OVF      = 3;
    localparam int STAT_IRQ_MASK = 4;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, 2**AW entries of DW bits.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [2**AW];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // Flags come from the current pointers, so a push while full is refused
    // even when a pop happens on the same clock.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_pop_ok)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 serial transmitter (DATA/STATUS registers, FIFO, baud FSM).
// Define UART_TX_IRQ_EN to add the irq output and the STATUS irq_mask bit.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h8410,
    parameter int          CLK_DIV   = 217,
    parameter int          FIFO_AW   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wr_stb,
    input  logic        bus_rd_stb,
    output logic [7:0]  bus_rdata,
    output logic        bus_hit,
`ifdef UART_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        tx
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    tx_state_t   r_state, w_state_nxt;
    logic [15:0] r_baud, w_baud_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_ovf;
    logic [7:0]  r_rdata;
    logic [7:0]  w_fifo_rdata;
    logic [7:0]  w_status;
    logic        w_full, w_empty, w_pop, w_busy, w_baud_done;
    logic        w_wr_data, w_wr_status, w_rd;

    assign bus_hit     = (bus_addr[15:1] == BASE_ADDR[15:1]);
    assign w_wr_data   = bus_wr_stb & bus_hit & (bus_addr[0] == REG_DATA);
    assign w_wr_status = bus_wr_stb & bus_hit & (bus_addr[0] == REG_STATUS);
    assign w_rd        = bus_rd_stb & bus_hit;
    assign w_busy      = (r_state != IDLE);
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign bus_rdata   = r_rdata;
    assign tx          = r_tx;

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_wr_data),
        .i_wdata (bus_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef UART_TX_IRQ_EN
    logic r_irq_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         r_irq_mask <= 1'b0;
        else if (w_wr_status) r_irq_mask <= bus_wdata[STAT_IRQ_MASK];
    end

    assign irq = r_irq_mask & ((w_empty & ~w_busy) | r_ovf);
`endif

    always_comb begin
        w_status = '0;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_BUSY]  = w_busy;
        w_status[STAT_OVF]   = r_ovf;
`ifdef UART_TX_IRQ_EN
        w_status[STAT_IRQ_MASK] = r_irq_mask;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            if (w_wr_data && w_full) r_ovf <= 1'b1;
            else if (w_wr_status)    r_ovf <= 1'b0;
            if (w_rd) r_rdata <= (bus_addr[0] == REG_STATUS) ? w_status : 8'h00;
        end
    end

    // tx is registered from the next-state decode so the line never glitches.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 16'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_baud_nxt = 16'd0;
                w_tx_nxt   = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_rdata;
                    w_state_nxt = START;
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = 16'd0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = 16'd0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt = 16'd0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_rdata;
                        w_state_nxt = START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: scoreboard bench for uart_tx_port with CLK_DIV=4, FIFO_AW=2.
// A background monitor decodes tx frames and pops expected bytes from the scoreboard queue.
module tb_uart_tx_port;

    localparam logic [15:0] A_DATA = 16'h8410;
    localparam logic [15:0] A_STAT = 16'h8411;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_wr_stb;
    logic        bus_rd_stb;
    logic [7:0]  bus_rdata;
    logic        bus_hit;
    logic        tx;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        mon_en   = 1'b1;
    logic [7:0]  sb_q [$];
    int          fr_start [$];

    uart_tx_port #(
        .BASE_ADDR (16'h8410),
        .CLK_DIV   (4),
        .FIFO_AW   (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wr_stb (bus_wr_stb),
        .bus_rd_stb (bus_rd_stb),
        .bus_rdata  (bus_rdata),
        .bus_hit    (bus_hit),
`ifdef UART_TX_IRQ_EN
        .irq        (irq),
`endif
        .tx         (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a negedge; the access lands on the posedge in between.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, output int e);
        bus_addr   = a;
        bus_wdata  = d;
        bus_wr_stb = 1'b1;
        @(negedge clk);
        bus_wr_stb = 1'b0;
        e = cyc;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        bus_addr   = a;
        bus_rd_stb = 1'b1;
        @(negedge clk);
        bus_rd_stb = 1'b0;
        d = bus_rdata;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin : monitor
        logic       prev;
        logic       s;
        logic       p;
        logic [7:0] d;
        logic [8:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !tx) begin
                fr_start.push_back(cyc);
                @(negedge clk);
                s = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    d[i] = tx;
                end
                repeat (4) @(negedge clk);
                p = tx;
                if (sb_q.size() > 0) exp = {1'b0, sb_q.pop_front()};
                else                 exp = 9'h100;
                check_val("frame_data", 32'(d), 32'(exp));
                check_val("frame_start_stop", 32'({s, p}), 32'd1);
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [15:0] hit_a [5];
        logic        hit_e [5];
        logic [7:0]  d;
        logic [7:0]  byt;
        int          w;
        int          w0;
        int          lows;

        hit_a = '{16'h8410, 16'h8411, 16'h8400, 16'h8412, 16'h0410};
        hit_e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        reset_n    = 1'b0;
        bus_addr   = 16'h0000;
        bus_wdata  = 8'h00;
        bus_wr_stb = 1'b0;
        bus_rd_stb = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_tx", 32'(tx), 32'd1);
        check_val("rst_rdata", 32'(bus_rdata), 32'h00);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            bus_addr = hit_a[i];
            #1;
            check_val($sformatf("bus_hit_%04h", hit_a[i]), 32'(bus_hit), 32'(hit_e[i]));
        end
        @(negedge clk);
        bus_read(A_STAT, d);
        check_val("rst_status", 32'(d), 32'h02);
        bus_read(A_DATA, d);
        check_val("data_read_zero", 32'(d), 32'h00);

        // Writes outside the decoded pair must not queue anything.
        bus_write(16'h8412, 8'h77, w);
        lows = 0;
        repeat (8) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check_val("nohit_tx_idle", 32'(lows), 32'd0);
        bus_read(A_STAT, d);
        check_val("nohit_status", 32'(d), 32'h02);

        // Single frame: start 1 clk after push, idle again after 40 clks.
        fr_start.delete();
        sb_q.push_back(8'hA5);
        bus_write(A_DATA, 8'hA5, w);
        wait_cyc(w + 40);
        bus_read(A_STAT, d);
        check_val("t1_busy_last", 32'(d), 32'h06);
        bus_read(A_STAT, d);
        check_val("t1_idle", 32'(d), 32'h02);
        check_val("t1_frames", 32'(fr_start.size()), 32'd1);
        if (fr_start.size() >= 1) check_val("t1_start_lat", 32'(fr_start[0] - w), 32'd1);

        // Six writes while idle: five accepted (one pop in between), sixth dropped.
        for (int i = 0; i < 6; i++) begin
            byt = 8'h11 + 8'(i);
            if (i < 5) sb_q.push_back(byt);
            bus_write(A_DATA, byt, w);
        end
        bus_read(A_STAT, d);
        check_val("t2_full_ovf", 32'(d), 32'h0D);
        wait_cyc(w + 5 * 40 + 4);
        check_val("t2_drained", 32'(sb_q.size()), 32'd0);
        bus_read(A_STAT, d);
        check_val("t2_ovf_sticky", 32'(d), 32'h0A);
        bus_write(A_STAT, 8'h00, w);
        bus_read(A_STAT, d);
        check_val("t2_ovf_clear", 32'(d), 32'h02);

        // Three queued frames run back to back.
        fr_start.delete();
        for (int i = 0; i < 3; i++) begin
            byt = (i == 0) ? 8'h3C : (i == 1) ? 8'hC3 : 8'h5A;
            sb_q.push_back(byt);
            bus_write(A_DATA, byt, w);
            if (i == 0) w0 = w;
        end
        wait_cyc(w0 + 120);
        bus_read(A_STAT, d);
        check_val("t3_busy_120", 32'(d), 32'h06);
        bus_read(A_STAT, d);
        check_val("t3_idle_121", 32'(d), 32'h02);
        check_val("t3_frames", 32'(fr_start.size()), 32'd3);
        if (fr_start.size() == 3) begin
            check_val("t3_gap01", 32'(fr_start[1] - fr_start[0]), 32'd40);
            check_val("t3_gap12", 32'(fr_start[2] - fr_start[1]), 32'd40);
        end

        // Write to a full FIFO on the clock the STOP state pops: dropped.
        for (int i = 0; i < 5; i++) begin
            byt = 8'h60 + 8'(i);
            sb_q.push_back(byt);
            bus_write(A_DATA, byt, w);
            if (i == 0) w0 = w;
        end
        wait_cyc(w0 + 40);
        bus_write(A_DATA, 8'hEE, w);
        bus_read(A_STAT, d);
        check_val("t5_ovf_count3", 32'(d), 32'h0C);
        bus_write(A_STAT, 8'h00, w);
        bus_read(A_STAT, d);
        check_val("t5_ovf_clear", 32'(d), 32'h04);
        wait_cyc(w0 + 5 * 40 + 10);
        check_val("t5_drained", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of data bit 3 (a 0 bit of 8'h55).
        mon_en = 1'b0;
        bus_write(A_DATA, 8'h55, w0);
        bus_write(A_DATA, 8'h55, w);
        wait_cyc(w0 + 18);
        check_val("t4_tx_bit3", 32'(tx), 32'd0);
        #2 reset_n = 1'b0;
        #1 check_val("t4_tx_async", 32'(tx), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(A_STAT, d);
        check_val("t4_status", 32'(d), 32'h02);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check_val("t4_fifo_lost", 32'(lows), 32'd0);
        mon_en = 1'b1;

`ifdef UART_TX_IRQ_EN
        check_val("irq_masked", 32'(irq), 32'd0);
        bus_write(A_STAT, 8'h10, w);
        check_val("irq_idle", 32'(irq), 32'd1);
        bus_read(A_STAT, d);
        check_val("irq_mask_bit", 32'(d), 32'h12);
        sb_q.push_back(8'h42);
        bus_write(A_DATA, 8'h42, w);
        check_val("irq_after_push", 32'(irq), 32'd0);
        wait_cyc(w + 40);
        check_val("irq_in_stop", 32'(irq), 32'd0);
        wait_cyc(w + 41);
        check_val("irq_after_stop", 32'(irq), 32'd1);
        repeat (4) @(negedge clk);
        check_val("irq_drained", 32'(sb_q.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
